led_matrix_scanner: RTL and testbench
=====================================

Name: led_matrix_scanner

Overview:
Time-multiplexed row scanner that sits directly upstream of led_matrix_encoder. It holds a double-buffered LED frame and steps through the matrix rows. For each row it drives a one-hot row strobe and that row's column pattern, with a blanking gap between rows to suppress ghosting. Frame bit numbering matches the encoder's data_idx convention: bit (r*CWIDTH + c) is row r, column c.

Parameters:
RWIDTH, 4, number of matrix rows (>=2)
CWIDTH, 4, number of matrix columns (>=1)
DWELL, 1000, clock cycles each row is driven (>=1)
BLANK, 16, clock cycles of all-off between rows (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 = matrix dark, scanner idle
frame_data  in  RWIDTH*CWIDTH  new frame; bit r*CWIDTH+c = LED(r,c)
frame_valid  in  1  frame_data valid (valid/ready handshake)
frame_ready  out  1  shadow buffer empty, can accept a frame
row_out  out  RWIDTH  one-hot active-high row strobe; all-zero when blank or idle
col_out  out  CWIDTH  active-high column drive for the current row
scan_idx  out  $clog2(RWIDTH)  index of the current row (held during BLANK)
frame_done  out  1  one-cycle pulse on the last DRIVE cycle of row RWIDTH-1

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - row_out=0, col_out=0, scan_idx=0, frame_done=0.
  - Active buffer=0, shadow buffer empty, so frame_ready=1.
  - State IDLE; counters 0.
- Handshake:
  - frame_ready = ~shadow_full (registered flag, not combinational from frame_valid).
  - On a cycle with frame_valid && frame_ready, frame_data is latched into shadow and shadow_full=1.
  - frame_data is ignored when frame_ready=0.
- FSM states: IDLE, BLANK, DRIVE. All outputs are registered.
  - IDLE: outputs 0; row and cycle counters held at 0. When en=1, go to BLANK with row 0.
  - BLANK: row_out=0, col_out=0 for exactly BLANK cycles, then DRIVE.
  - DRIVE: row_out=1<<scan_idx and col_out=active[scan_idx*CWIDTH +: CWIDTH] for exactly DWELL cycles.
  - End of DRIVE: scan_idx increments and wraps RWIDTH-1 -> 0; go to BLANK.
- Row period is BLANK+DWELL cycles; frame period is RWIDTH*(BLANK+DWELL) cycles.
- Frame swap:
  - Happens on the cycle frame_done is asserted, and only if shadow_full was already set before that cycle.
  - Swap copies shadow to active and clears shadow_full, so frame_ready returns to 1 on the next cycle.
  - A frame accepted in the same cycle as frame_done is held in shadow until the next frame boundary.
  - The active buffer never changes mid-frame, so there is no tearing.
- en deassert in any state:
  - Next edge goes to IDLE; outputs 0; scan_idx=0.
  - Active and shadow buffers are retained, and the handshake stays operational.
  - Re-enable restarts at BLANK, row 0.
- Asynchronous reset mid-scan: immediate return to reset values; the shadow contents are discarded.
- Counters are sized $clog2(max(DWELL,BLANK)+1); no overflow is possible.

Optional Feature:
SCAN_PWM_EN
- Defined:
  - Adds input brightness[3:0].
  - A 4-bit free-running pwm counter increments every DRIVE cycle and clears on entering DRIVE.
  - col_out is forced to 0 while pwm_cnt >= brightness. brightness=0 keeps columns dark; 15 gives 15/16 duty.
  - row_out is unaffected.
  - brightness is sampled once per row, at BLANK->DRIVE.
- Undefined: no brightness port; col_out is driven for the full DWELL.

Test Plan:
Use RWIDTH=4, CWIDTH=4, DWELL=4, BLANK=2 for all scenarios.
1. Reset, then en=1 with no frame -> frame_ready=1; row_out cycles 0000 x2, 0001 x4, 0000 x2, 0010 x4 ...; col_out=0000 throughout; frame_done every 24 cycles.
2. Load 16'h8421 in IDLE, en=1 -> first frame uses old active=0; after the swap at the first frame_done, rows 0..3 show col_out 0001, 0010, 0100, 1000; frame_ready drops to 0 on load and returns to 1 the cycle after the swap.
3. Load 16'hFFFF mid-frame, then attempt 16'h0000 while frame_ready=0 -> second frame ignored; 16'hFFFF appears only after the next frame_done; no mid-frame change to col_out.
4. frame_valid asserted on the exact frame_done cycle with the shadow empty -> frame accepted into shadow; displayed only after the following frame_done.
5. Drop en during DRIVE of row 2 -> next cycle row_out=0, col_out=0, scan_idx=0; re-enable -> 2 blank cycles, then row 0 with the retained active pattern.
6. rst_n low mid-DRIVE -> outputs clear asynchronously without waiting for a clock edge. Additionally, with SCAN_PWM_EN and brightness=2, frame 16'hFFFF: col_out=1111 for 2 of the 4 DRIVE cycles per row, else 0000.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Time-multiplexed row scanner for an RWIDTH x CWIDTH LED matrix. It holds a
//   double-buffered frame (active + shadow) and walks the rows. Each row gets
//   BLANK all-off cycles followed by DWELL cycles of row strobe plus column data.
//   Frame bit r*CWIDTH+c is LED(row r, column c).
//
//   Optional build macro: SCAN_PWM_EN adds a 4-bit brightness input. Columns are
//   then gated by a per-row PWM counter.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          scan enable (0 = dark/idle)
//   frame_data  new frame, valid/ready handshake with frame_valid/frame_ready
//   frame_valid frame_data valid
//   frame_ready shadow buffer empty (registered)
//   row_out     one-hot row strobe, zero while blanking or idle
//   col_out     column drive for the current row
//   scan_idx    current row index
//   frame_done  one-cycle pulse on the last DRIVE cycle of the last row
//   brightness  (SCAN_PWM_EN only) 0..15 duty in sixteenths
module led_matrix_scanner #(
    parameter int RWIDTH = 4,
    parameter int CWIDTH = 4,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [RWIDTH*CWIDTH-1:0]   frame_data,
    input  logic                       frame_valid,
`ifdef SCAN_PWM_EN
    input  logic [3:0]                 brightness,
`endif
    output logic                       frame_ready,
    output logic [RWIDTH-1:0]          row_out,
    output logic [CWIDTH-1:0]          col_out,
    output logic [$clog2(RWIDTH)-1:0]  scan_idx,
    output logic                       frame_done
);

    localparam int FW      = RWIDTH * CWIDTH;
    localparam int RW      = $clog2(RWIDTH);
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [RW-1:0]    ROW_LAST   = RW'(RWIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [RW-1:0]    row_n;
    logic [FW-1:0]    active, active_n;
    logic [FW-1:0]    shadow;
    logic             swap, accept, drive_n, done_n;
    logic [RWIDTH-1:0] row_hot_n;
    logic [CWIDTH-1:0] col_n;

`ifdef SCAN_PWM_EN
    logic [3:0] pwm_cnt, pwm_n;
    logic [3:0] bright, bright_n;
    logic       enter_drive;
`endif

    // Next-state logic; outputs are registered from the next-state values so
    // they line up with the state they describe.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = scan_idx;
        if (!en) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            row_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                    row_n   = '0;
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = ST_DRIVE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        state_n = ST_BLANK;
                        cnt_n   = '0;
                        row_n   = (scan_idx == ROW_LAST) ? '0 : scan_idx + RW'(1);
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    row_n   = '0;
                end
            endcase
        end
    end

    // Swap only when the shadow was already full during the frame_done cycle;
    // a frame accepted on that same edge waits for the next frame boundary.
    assign swap     = frame_done & ~frame_ready;
    assign accept   = frame_valid & frame_ready;
    assign active_n = swap ? shadow : active;
    assign drive_n  = (state_n == ST_DRIVE);
    assign done_n   = drive_n && (row_n == ROW_LAST) && (cnt_n == DWELL_LAST);

    always_comb begin
        row_hot_n        = '0;
        row_hot_n[row_n] = 1'b1;
        col_n            = active_n[row_n*CWIDTH +: CWIDTH];
`ifdef SCAN_PWM_EN
        if (pwm_n >= bright_n) begin
            col_n = '0;
        end
`endif
    end

`ifdef SCAN_PWM_EN
    assign enter_drive = (state == ST_BLANK) && (state_n == ST_DRIVE);
    assign bright_n    = enter_drive ? brightness : bright;
    assign pwm_n       = enter_drive ? 4'd0 :
                         (state == ST_DRIVE) ? pwm_cnt + 4'd1 : pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            bright  <= '0;
        end else begin
            pwm_cnt <= pwm_n;
            bright  <= bright_n;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            scan_idx    <= '0;
            active      <= '0;
            frame_ready <= 1'b1;
            row_out     <= '0;
            col_out     <= '0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            scan_idx   <= row_n;
            active     <= active_n;
            row_out    <= drive_n ? row_hot_n : '0;
            col_out    <= drive_n ? col_n : '0;
            frame_done <= done_n;
            if (swap) begin
                frame_ready <= 1'b1;
            end else if (accept) begin
                frame_ready <= 1'b0;
            end
        end
    end

    // Shadow contents are don't-care while frame_ready=1, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            shadow <= frame_data;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int D  = 4;
    localparam int B  = 2;
    localparam int RP = B + D;
    localparam int FP = R * RP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  row_out;
    logic [3:0]  col_out;
    logic [1:0]  scan_idx;
    logic        frame_done;
`ifdef SCAN_PWM_EN
    logic [3:0]  brightness;
`endif

    always #5 clk = ~clk;

    led_matrix_scanner #(
        .RWIDTH(R), .CWIDTH(C), .DWELL(D), .BLANK(B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
`ifdef SCAN_PWM_EN
        .brightness  (brightness),
`endif
        .frame_ready (frame_ready),
        .row_out     (row_out),
        .col_out     (col_out),
        .scan_idx    (scan_idx),
        .frame_done  (frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position within the frame period, plus the two buffers.
    bit          m_run;
    int          m_t;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_sfull;
    bit          m_fd;
    int          m_bright;
    logic [3:0]  e_row;
    logic [3:0]  e_col;
    int          e_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0; m_active = '0; m_shadow = '0;
        m_sfull = 0; m_fd = 0; m_bright = 0;
        e_row = '0; e_col = '0; e_idx = 0;
    endtask

    task automatic model_edge();
        bit fd_prev    = m_fd;
        bit sfull_prev = m_sfull;
        int row, off;
        if (fd_prev && sfull_prev) begin
            m_active = m_shadow;
            m_sfull  = 0;
        end
        if (frame_valid && !sfull_prev) begin
            m_shadow = frame_data;
            m_sfull  = 1;
        end
        if (!en) begin
            m_run = 0; m_t = 0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0;
        end else begin
            m_t = (m_t + 1) % FP;
        end
        e_row = '0; e_col = '0; e_idx = 0; m_fd = 0;
        if (m_run) begin
            row   = m_t / RP;
            off   = m_t % RP;
            e_idx = row;
`ifdef SCAN_PWM_EN
            if (off == B) m_bright = int'(brightness);
`endif
            if (off >= B) begin
                e_row = 4'(1 << row);
                e_col = m_active[row*C +: C];
                m_fd  = (row == R - 1) && (off == RP - 1);
`ifdef SCAN_PWM_EN
                if ((off - B) % 16 >= m_bright) e_col = '0;
`endif
            end
        end
    endtask

    task automatic check_outputs();
        check("row_out",     32'(row_out),     32'(e_row));
        check("col_out",     32'(col_out),     32'(e_col));
        check("scan_idx",    32'(scan_idx),    32'(e_idx));
        check("frame_done",  32'(frame_done),  32'(m_fd));
        check("frame_ready", 32'(frame_ready), 32'(!m_sfull));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        int  waited;
        bit  found;

        rst_n = 1'b0; en = 1'b0; frame_valid = 1'b0; frame_data = '0;
`ifdef SCAN_PWM_EN
        brightness = 4'd15;
`endif
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Free run with the reset (all-zero) frame.
        en = 1'b1;
        repeat (2 * FP) step();

        // Load a frame while idle, then enable.
        en = 1'b0;
        step();
        frame_data = 16'h8421; frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        step();
        en = 1'b1;
        repeat (2 * FP + 4) step();

        // Mid-frame load, then a second offer while the shadow is full.
        repeat (7) step();
        frame_data = 16'hFFFF; frame_valid = 1'b1;
        step();
        frame_data = 16'h0000;
        repeat (2) step();
        frame_valid = 1'b0;
        repeat (2 * FP) step();

        // Offer a frame exactly on the frame_done cycle with the shadow empty.
        found = 0;
        for (waited = 0; waited < 4 * FP && !found; waited++) begin
            step();
            if (m_fd && !m_sfull) found = 1;
        end
        check("fd_wait", 32'(found), 32'd1);
        frame_data = 16'h1248; frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        repeat (2 * FP) step();

        // Drop enable during DRIVE of row 2, then re-enable.
        found = 0;
        for (waited = 0; waited < 4 * FP && !found; waited++) begin
            step();
            if (m_run && (m_t / RP == 2) && (m_t % RP == B + 1)) found = 1;
        end
        check("row2_wait", 32'(found), 32'd1);
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (FP + 2) step();

        // Asynchronous reset mid-DRIVE.
        found = 0;
        for (waited = 0; waited < 4 * FP && !found; waited++) begin
            step();
            if (m_run && (m_t / RP == 1) && (m_t % RP == B + 1)) found = 1;
        end
        check("row1_wait", 32'(found), 32'd1);
        check("pre_rst_row", 32'(row_out), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (FP) step();

`ifdef SCAN_PWM_EN
        // Half-brightness full frame.
        brightness = 4'd2;
        frame_data = 16'hFFFF; frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        repeat (3 * FP) step();
`endif

        // Randomized traffic against the model.
        repeat (1500) begin
            en          = ($urandom_range(0, 59) != 0);
            frame_valid = ($urandom_range(0, 3) == 0);
            frame_data  = 16'($urandom);
`ifdef SCAN_PWM_EN
            if ($urandom_range(0, 7) == 0) brightness = 4'($urandom);
`endif
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
